// File: rtl/ordena8_unloader.sv
// ordena8_unloader
// Captures one parallel 8-word frame from the Ordena8 sorter and streams it out
// one word per beat on a valid/ready port, lowest index first. It also checks
// each captured frame for monotonic order.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   in_valid / in_ready   capture handshake for the parallel frame out1..out8
//   out1..out8            sorted words from the sorter (unsigned, WIDTH bits)
//   dout, dout_idx        current serial word and its index (0 = out1)
//   dout_valid/dout_ready serial handshake; dout_last marks index 7
//   order_err, err_cnt    sticky bad-order flag and saturating bad-frame count
//   frames_done           frames fully streamed, wraps modulo 2^16
module ordena8_unloader #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          DESCENDING = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] out1,
  input  logic [WIDTH-1:0] out2,
  input  logic [WIDTH-1:0] out3,
  input  logic [WIDTH-1:0] out4,
  input  logic [WIDTH-1:0] out5,
  input  logic [WIDTH-1:0] out6,
  input  logic [WIDTH-1:0] out7,
  input  logic [WIDTH-1:0] out8,
  output logic [WIDTH-1:0] dout,
  output logic [2:0]       dout_idx,
  output logic             dout_valid,
  output logic             dout_last,
  input  logic             dout_ready,
  output logic             order_err,
  output logic [7:0]       err_cnt,
  output logic [15:0]      frames_done
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e           state_q;
  logic [2:0]       idx_q;
  logic [WIDTH-1:0] cap_buf_q [8];
  logic [WIDTH-1:0] dout_q;
  logic             dout_valid_q;
  logic             order_err_q;
  logic [7:0]       err_cnt_q;
  logic [15:0]      frames_done_q;

  logic [WIDTH-1:0] in_w [8];
  logic             order_bad;
  logic             last_beat;
  logic             capture;

  always_comb begin
    in_w[0] = out1;
    in_w[1] = out2;
    in_w[2] = out3;
    in_w[3] = out4;
    in_w[4] = out5;
    in_w[5] = out6;
    in_w[6] = out7;
    in_w[7] = out8;
  end

  // Equal neighbours are legal in both directions.
  always_comb begin
    order_bad = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (DESCENDING) begin
        if (in_w[k] < in_w[k+1]) order_bad = 1'b1;
      end else begin
        if (in_w[k] > in_w[k+1]) order_bad = 1'b1;
      end
    end
  end

  assign last_beat = (state_q == StSend) && (idx_q == 3'd7);
  // Opening the input on the accepted final beat lets the next frame follow
  // without a bubble.
  assign in_ready  = (state_q == StIdle) || (last_beat && dout_ready);
  assign capture   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      idx_q         <= 3'd0;
      dout_q        <= '0;
      dout_valid_q  <= 1'b0;
      order_err_q   <= 1'b0;
      err_cnt_q     <= 8'd0;
      frames_done_q <= 16'd0;
      for (int i = 0; i < 8; i++) cap_buf_q[i] <= '0;
    end else begin
      if (capture) begin
        cap_buf_q    <= in_w;
        idx_q        <= 3'd0;
        dout_q       <= out1;
        dout_valid_q <= 1'b1;
        state_q      <= StSend;
        if (order_bad) begin
          order_err_q <= 1'b1;
          if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
        end
      end else if ((state_q == StSend) && dout_ready) begin
        if (idx_q == 3'd7) begin
          state_q      <= StIdle;
          dout_valid_q <= 1'b0;
          idx_q        <= 3'd0;
        end else begin
          idx_q  <= idx_q + 3'd1;
          dout_q <= cap_buf_q[idx_q + 3'd1];
        end
      end
      if (last_beat && dout_ready) frames_done_q <= frames_done_q + 16'd1;
    end
  end

  assign dout        = dout_q;
  assign dout_idx    = idx_q;
  assign dout_valid  = dout_valid_q;
  assign dout_last   = last_beat;
  assign order_err   = order_err_q;
  assign err_cnt     = err_cnt_q;
  assign frames_done = frames_done_q;

endmodule

// File: tb/tb_ordena8_unloader.sv
// Directed bench for ordena8_unloader: an ascending instance exercises all the
// streaming behaviour, a descending instance sharing the same inputs checks
// the reversed order rule.
module tb_ordena8_unloader;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] o [8];
  logic       dout_ready;

  logic       a_in_ready, a_dout_valid, a_dout_last, a_order_err;
  logic [7:0] a_dout, a_err_cnt;
  logic [2:0] a_dout_idx;
  logic [15:0] a_frames_done;

  logic       d_in_ready, d_dout_valid, d_dout_last, d_order_err;
  logic [7:0] d_dout, d_err_cnt;
  logic [2:0] d_dout_idx;
  logic [15:0] d_frames_done;

  int tests;
  int fails;

  ordena8_unloader #(.WIDTH(8), .DESCENDING(1'b0)) u_asc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .out1(o[0]), .out2(o[1]), .out3(o[2]), .out4(o[3]),
    .out5(o[4]), .out6(o[5]), .out7(o[6]), .out8(o[7]),
    .dout(a_dout), .dout_idx(a_dout_idx), .dout_valid(a_dout_valid),
    .dout_last(a_dout_last), .dout_ready(dout_ready), .order_err(a_order_err),
    .err_cnt(a_err_cnt), .frames_done(a_frames_done)
  );

  ordena8_unloader #(.WIDTH(8), .DESCENDING(1'b1)) u_desc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d_in_ready),
    .out1(o[0]), .out2(o[1]), .out3(o[2]), .out4(o[3]),
    .out5(o[4]), .out6(o[5]), .out7(o[6]), .out8(o[7]),
    .dout(d_dout), .dout_idx(d_dout_idx), .dout_valid(d_dout_valid),
    .dout_last(d_dout_last), .dout_ready(dout_ready), .order_err(d_order_err),
    .err_cnt(d_err_cnt), .frames_done(d_frames_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_frame(input logic [7:0] w [8]);
    for (int i = 0; i < 8; i++) o[i] = w[i];
  endtask

  // Capture w from idle and stream it with dout_ready held high, checking every beat.
  task automatic stream_check(input logic [7:0] w [8], input string tag);
    set_frame(w);
    in_valid = 1'b1;
    dout_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, a_in_ready, 1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_dout"}, a_dout, w[i]);
      chk({tag, "_idx"}, a_dout_idx, i);
      tick();
    end
    chk({tag, "_valid_end"}, a_dout_valid, 0);
  endtask

  // Same handshake without per-beat checks, used for bulk repetition.
  task automatic stream_quiet(input logic [7:0] w [8]);
    set_frame(w);
    in_valid = 1'b1;
    dout_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
  endtask

  initial begin
    logic [7:0] f [8];
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    dout_ready = 1'b0;
    for (int i = 0; i < 8; i++) o[i] = 8'd0;
    #12;
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_valid", a_dout_valid, 0);
    chk("rst_last", a_dout_last, 0);
    chk("rst_dout", a_dout, 0);
    chk("rst_idx", a_dout_idx, 0);
    chk("rst_frames", a_frames_done, 0);
    chk("rst_err", a_order_err, 0);
    #3;
    rst_n = 1'b1;
    tick();

    // 1: ascending frame, ready held high, 1-clock capture latency.
    f = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    set_frame(f);
    in_valid = 1'b1;
    dout_ready = 1'b1;
    #1;
    chk("t1_valid_before", a_dout_valid, 0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t1_valid", a_dout_valid, 1);
      chk("t1_dout", a_dout, i + 1);
      chk("t1_last", a_dout_last, (i == 7) ? 1 : 0);
      if (i < 7) chk("t1_in_ready_busy", a_in_ready, 0);
      tick();
    end
    chk("t1_valid_end", a_dout_valid, 0);
    chk("t1_frames", a_frames_done, 1);
    chk("t1_err", a_order_err, 0);

    // 2: equal values with ready toggling; each beat held while ready is low.
    f = '{8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9};
    set_frame(f);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int b = 0; b < 8; b++) begin
      dout_ready = 1'b0;
      tick();
      chk("t2_hold_valid", a_dout_valid, 1);
      chk("t2_hold_idx", a_dout_idx, b);
      chk("t2_hold_dout", a_dout, 9);
      chk("t2_hold_last", a_dout_last, (b == 7) ? 1 : 0);
      dout_ready = 1'b1;
      tick();
    end
    chk("t2_valid_end", a_dout_valid, 0);
    chk("t2_frames", a_frames_done, 2);
    chk("t2_err", a_order_err, 0);

    // 3: bad frame still streams unchanged; error sticks and saturates.
    f = '{8'd5, 8'd3, 8'd7, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11};
    stream_check(f, "t3_bad");
    chk("t3_err", a_order_err, 1);
    chk("t3_cnt", a_err_cnt, 1);
    f = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    stream_check(f, "t3_good");
    chk("t3_err_sticky", a_order_err, 1);
    chk("t3_cnt_after_good", a_err_cnt, 1);
    f = '{8'd5, 8'd3, 8'd7, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11};
    for (int r = 0; r < 300; r++) stream_quiet(f);
    chk("t3_cnt_sat", a_err_cnt, 255);
    chk("t3_frames", a_frames_done, 304);

    // 4: back-to-back frames with no bubble.
    f = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17};
    set_frame(f);
    in_valid = 1'b1;
    dout_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t4_a_valid", a_dout_valid, 1);
      chk("t4_a_dout", a_dout, 10 + i);
      if (i == 7) begin
        f = '{8'd20, 8'd21, 8'd22, 8'd23, 8'd24, 8'd25, 8'd26, 8'd27};
        set_frame(f);
        in_valid = 1'b1;
        #1;
        chk("t4_in_ready_last", a_in_ready, 1);
      end
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t4_b_valid", a_dout_valid, 1);
      chk("t4_b_dout", a_dout, 20 + i);
      chk("t4_b_idx", a_dout_idx, i);
      tick();
    end
    chk("t4_valid_end", a_dout_valid, 0);
    chk("t4_frames", a_frames_done, 306);

    // 5: asynchronous reset at idx 4 abandons the frame.
    f = '{8'd30, 8'd31, 8'd32, 8'd33, 8'd34, 8'd35, 8'd36, 8'd37};
    set_frame(f);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t5_idx4", a_dout_idx, 4);
    chk("t5_dout4", a_dout, 34);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", a_dout_valid, 0);
    chk("t5_rst_in_ready", a_in_ready, 1);
    chk("t5_rst_idx", a_dout_idx, 0);
    chk("t5_rst_frames", a_frames_done, 0);
    chk("t5_rst_cnt", a_err_cnt, 0);
    #2;
    rst_n = 1'b1;
    tick();
    f = '{8'd40, 8'd41, 8'd42, 8'd43, 8'd44, 8'd45, 8'd46, 8'd47};
    stream_check(f, "t5_new");
    chk("t5_frames_new", a_frames_done, 1);

    // 6: descending instance order rule.
    #2;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
    f = '{8'd200, 8'd150, 8'd150, 8'd90, 8'd60, 8'd30, 8'd10, 8'd0};
    stream_check(f, "t6_desc");
    chk("t6_desc_err_ok", d_order_err, 0);
    chk("t6_asc_err_bad", a_order_err, 1);
    chk("t6_desc_frames", d_frames_done, 1);
    f = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    stream_check(f, "t6_asc");
    chk("t6_desc_err_bad", d_order_err, 1);
    chk("t6_desc_cnt", d_err_cnt, 1);
    chk("t6_asc_cnt", a_err_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
